// File: rtl/cpu6502_pkg.sv
// Types and constants shared by the 6502 program-counter datapath.
package cpu6502_pkg;

  typedef logic [15:0] pc_t;
  typedef logic [7:0]  byte_t;

  localparam pc_t   RESET_PC_DEF = 16'hFFFC;
  localparam byte_t BUS_IDLE     = 8'h00;

endpackage

// File: rtl/pc_half.sv
// One byte of the program counter: select latch, incrementer with carry
// chain, and the PC byte register.
module pc_half
  import cpu6502_pkg::*;
#(
  parameter byte_t RST_VAL = 8'h00
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  rdy_i,
  input  logic  loop_sel_i,
  input  logic  bus_sel_i,
  input  byte_t bus_data_i,
  input  logic  cin_i,
  output logic  cout_o,
  output byte_t next_o,
  output byte_t pc_o
);

  byte_t pc_q, pc_d;
  byte_t sel_q, sel_d;

  // Bus load beats the loop; with neither asserted the latch keeps its last pick.
  always_comb begin
    sel_d = sel_q;
    if (bus_sel_i) begin
      sel_d = bus_data_i;
    end else if (loop_sel_i) begin
      sel_d = pc_q;
    end
  end

  assign {cout_o, pc_d} = {1'b0, sel_d} + {8'h00, cin_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RST_VAL;
      sel_q <= RST_VAL;
    end else if (rdy_i) begin
      pc_q  <= pc_d;
      sel_q <= sel_d;
    end
  end

  assign next_o = pc_d;
  assign pc_o   = pc_q;

endmodule

// File: rtl/pc_unit.sv
// 6502 program counter: two pc_half instances plus DB/ADL/ADH bus drive.
// Optional breakpoint comparator enabled by defining PC_BREAK_EN.
module pc_unit
  import cpu6502_pkg::*;
#(
  parameter pc_t         RESET_PC = RESET_PC_DEF,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RDY,
  input  logic             PCL_PCL,
  input  logic             ADL_PCL,
  input  logic             PCH_PCH,
  input  logic             ADH_PCH,
  input  logic             I_PC,
  input  logic             PCL_DB,
  input  logic             PCL_ADL,
  input  logic             PCH_DB,
  input  logic             PCH_ADH,
  input  logic [WIDTH-1:0] ADL_DATA,
  input  logic [WIDTH-1:0] ADH_DATA,
`ifdef PC_BREAK_EN
  input  logic [15:0]      BRK_ADDR,
  input  logic             BRK_ARM,
  output logic             BRK_HIT,
`endif
  output logic [WIDTH-1:0] DB_OUT,
  output logic             DB_OE,
  output logic [WIDTH-1:0] ADL_OUT,
  output logic             ADL_OE,
  output logic [WIDTH-1:0] ADH_OUT,
  output logic             ADH_OE,
  output logic [15:0]      PC_OUT,
  output logic [WIDTH-1:0] PCL_LOOP
);

  byte_t pcl, pch, nextl, nexth;
  logic  carry_lo;
  logic  unused_cout_hi;

  pc_half #(.RST_VAL(RESET_PC[7:0])) u_lo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rdy_i      (RDY),
    .loop_sel_i (PCL_PCL),
    .bus_sel_i  (ADL_PCL),
    .bus_data_i (ADL_DATA),
    .cin_i      (I_PC),
    .cout_o     (carry_lo),
    .next_o     (nextl),
    .pc_o       (pcl)
  );

  // High-byte carry out is dropped: FFFF+1 wraps silently.
  pc_half #(.RST_VAL(RESET_PC[15:8])) u_hi (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rdy_i      (RDY),
    .loop_sel_i (PCH_PCH),
    .bus_sel_i  (ADH_PCH),
    .bus_data_i (ADH_DATA),
    .cin_i      (carry_lo),
    .cout_o     (unused_cout_hi),
    .next_o     (nexth),
    .pc_o       (pch)
  );

  assign PC_OUT   = {pch, pcl};
  assign PCL_LOOP = pcl;

  always_comb begin
    DB_OUT  = BUS_IDLE;
    DB_OE   = 1'b0;
    ADL_OUT = BUS_IDLE;
    ADL_OE  = 1'b0;
    ADH_OUT = BUS_IDLE;
    ADH_OE  = 1'b0;
    if (!RST) begin
      if (PCL_DB) begin
        DB_OUT = pcl;
      end else if (PCH_DB) begin
        DB_OUT = pch;
      end
      DB_OE = PCL_DB | PCH_DB;
      if (PCL_ADL) begin
        ADL_OUT = pcl;
        ADL_OE  = 1'b1;
      end
      if (PCH_ADH) begin
        ADH_OUT = pch;
        ADH_OE  = 1'b1;
      end
    end
  end

  db_contention_a: assert property (@(posedge CLK) disable iff (RST) !(PCL_DB && PCH_DB));

`ifdef PC_BREAK_EN
  logic brk_hit_q, brk_hit_d;

  always_comb begin
    brk_hit_d = brk_hit_q;
    if (!BRK_ARM) begin
      brk_hit_d = 1'b0;
    end else if (RDY && ({nexth, nextl} == BRK_ADDR)) begin
      brk_hit_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      brk_hit_q <= 1'b0;
    end else begin
      brk_hit_q <= brk_hit_d;
    end
  end

  assign BRK_HIT = brk_hit_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized stimulus
// against a 16-bit arithmetic model of the program counter.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST, RDY;
  logic        PCL_PCL, ADL_PCL, PCH_PCH, ADH_PCH, I_PC;
  logic        PCL_DB, PCL_ADL, PCH_DB, PCH_ADH;
  logic [7:0]  ADL_DATA, ADH_DATA;
  logic [7:0]  DB_OUT, ADL_OUT, ADH_OUT, PCL_LOOP;
  logic        DB_OE, ADL_OE, ADH_OE;
  logic [15:0] PC_OUT;
`ifdef PC_BREAK_EN
  logic [15:0] BRK_ADDR;
  logic        BRK_ARM, BRK_HIT;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: PC value and the last selected low/high bytes.
  int unsigned m_pc, m_sell, m_selh;

  always #5 CLK = ~CLK;

  pc_unit #(.RESET_PC(16'hFFFC), .WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RDY(RDY),
    .PCL_PCL(PCL_PCL), .ADL_PCL(ADL_PCL), .PCH_PCH(PCH_PCH), .ADH_PCH(ADH_PCH),
    .I_PC(I_PC), .PCL_DB(PCL_DB), .PCL_ADL(PCL_ADL), .PCH_DB(PCH_DB), .PCH_ADH(PCH_ADH),
    .ADL_DATA(ADL_DATA), .ADH_DATA(ADH_DATA),
`ifdef PC_BREAK_EN
    .BRK_ADDR(BRK_ADDR), .BRK_ARM(BRK_ARM), .BRK_HIT(BRK_HIT),
`endif
    .DB_OUT(DB_OUT), .DB_OE(DB_OE), .ADL_OUT(ADL_OUT), .ADL_OE(ADL_OE),
    .ADH_OUT(ADH_OUT), .ADH_OE(ADH_OE), .PC_OUT(PC_OUT), .PCL_LOOP(PCL_LOOP)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic ctl(input logic rdy, input logic pl, input logic al, input logic ph,
                     input logic ah, input logic inc, input logic [7:0] adl, input logic [7:0] adh);
    RDY = rdy; PCL_PCL = pl; ADL_PCL = al; PCH_PCH = ph; ADH_PCH = ah;
    I_PC = inc; ADL_DATA = adl; ADH_DATA = adh;
  endtask

  task automatic bus(input logic ldb, input logic ladl, input logic hdb, input logic hadh);
    PCL_DB = ldb; PCL_ADL = ladl; PCH_DB = hdb; PCH_ADH = hadh;
  endtask

  // Advance one clock: update the model from the present inputs, then compare.
  task automatic step();
    int unsigned sel16;
    if (RDY) begin
      if (ADL_PCL) m_sell = ADL_DATA;
      else if (PCL_PCL) m_sell = m_pc % 256;
      if (ADH_PCH) m_selh = ADH_DATA;
      else if (PCH_PCH) m_selh = m_pc / 256;
      sel16 = m_selh * 256 + m_sell;
      m_pc  = (sel16 + (I_PC ? 1 : 0)) % 65536;
    end
    @(posedge CLK);
    #1;
    chk("pc", PC_OUT, m_pc);
    chk("pcl_loop", PCL_LOOP, m_pc % 256);
  endtask

  task automatic chk_bus();
    int unsigned lo, hi;
    lo = m_pc % 256;
    hi = m_pc / 256;
    #1;
    chk("db_out", DB_OUT, PCL_DB ? lo : (PCH_DB ? hi : 0));
    chk("db_oe", DB_OE, (PCL_DB || PCH_DB) ? 1 : 0);
    chk("adl_out", ADL_OUT, PCL_ADL ? lo : 0);
    chk("adl_oe", ADL_OE, PCL_ADL ? 1 : 0);
    chk("adh_out", ADH_OUT, PCH_ADH ? hi : 0);
    chk("adh_oe", ADH_OE, PCH_ADH ? 1 : 0);
  endtask

  initial begin
    RST = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef PC_BREAK_EN
    BRK_ADDR = 16'h0203; BRK_ARM = 1'b0;
`endif
    m_pc = 16'hFFFC; m_sell = 0; m_selh = 0;

    // Reset: outputs gated even with enables requested.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", PC_OUT, 16'hFFFC);
    chk("rst_db_oe", DB_OE, 0);
    chk("rst_adl_oe", ADL_OE, 0);
    chk("rst_adh_oe", ADH_OE, 0);
    chk("rst_adl_out", ADL_OUT, 0);
    chk("rst_adh_out", ADH_OUT, 0);
    chk("rst_db_out", DB_OUT, 0);
    RST = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0);

    // Loop increment from the reset vector, then wrap through FFFF.
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step(); chk("inc1", PC_OUT, 16'hFFFD);
    step(); chk("inc2", PC_OUT, 16'hFFFE);
    step(); chk("inc3", PC_OUT, 16'hFFFF);
    step(); chk("wrap_ffff", PC_OUT, 16'h0000);

    // Jump load, with and without increment, and bus beating loop.
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h34, 8'h56);
    step(); chk("jump", PC_OUT, 16'h5634);
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 8'h56);
    step(); chk("jump_inc", PC_OUT, 16'h5635);
    ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h34, 8'h56);
    step(); chk("jump_prio", PC_OUT, 16'h5635);

    // Low-byte carry into high byte.
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h12);
    step(); chk("load_12ff", PC_OUT, 16'h12FF);
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step(); chk("carry", PC_OUT, 16'h1300);

    // Stall freezes everything; resume counts again.
    RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("stall", PC_OUT, 16'h1300);
    end
    RDY = 1'b1;
    step(); chk("resume1", PC_OUT, 16'h1301);
    step(); chk("resume2", PC_OUT, 16'h1302);
    // No select: latch holds last selected value (1301), not current PC.
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(); chk("held_sel", PC_OUT, 16'h1302);

    // Bus drive from ABCD.
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hCD, 8'hAB);
    step();
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    bus(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("adl_abcd", ADL_OUT, 8'hCD);
    chk("adh_abcd", ADH_OUT, 8'hAB);
    chk("adl_oe_abcd", ADL_OE, 1);
    chk("adh_oe_abcd", ADH_OE, 1);
    bus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("db_pch", DB_OUT, 8'hAB);
    chk("db_oe_pch", DB_OE, 1);
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    chk_bus();

    // Reset in the middle of an increment cycle.
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_pc", PC_OUT, 16'hFFFC);
    RST = 1'b0;
    m_pc = 16'hFFFC;
    step(); chk("post_rst_inc", PC_OUT, 16'hFFFD);

`ifdef PC_BREAK_EN
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02);
    step();
    chk("brk_idle", BRK_HIT, 0);
    BRK_ARM = 1'b1;
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step(); chk("brk_0201", BRK_HIT, 0);
    step(); chk("brk_0202", BRK_HIT, 0);
    step(); chk("brk_0203", BRK_HIT, 1);
    chk("brk_pc", PC_OUT, 16'h0203);
    step(); chk("brk_sticky", BRK_HIT, 1);
    BRK_ARM = 1'b0;
    step(); chk("brk_clear", BRK_HIT, 0);
`endif

    // Randomized traffic; DB enables never both high.
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      RDY      = ($urandom_range(0, 3) != 0);
      PCL_PCL  = $urandom_range(0, 1) != 0;
      ADL_PCL  = ($urandom_range(0, 3) == 0);
      PCH_PCH  = $urandom_range(0, 1) != 0;
      ADH_PCH  = ($urandom_range(0, 3) == 0);
      I_PC     = $urandom_range(0, 1) != 0;
      ADL_DATA = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      ADH_DATA = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      r = $urandom_range(0, 2);
      bus(r == 1, $urandom_range(0, 1) != 0, r == 2, $urandom_range(0, 1) != 0);
      chk_bus();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter datapath for the 6502 core: the PCLS/PCHS select stage, the increment logic and the PCL/PCH registers, merged into one clocked block.
- It produces the incremented PCL value that the PCL register stage consumes. It also drives PCL onto the DB/ADL buses and PCH onto the DB/ADH buses.
- All state updates on the CLK rising edge. Bus drives are combinational from the registered PC.

Parameters:
RESET_PC, 16'hFFFC, PC value loaded on reset (low byte of the reset vector fetch address).
WIDTH, 8, width of each PC half; fixed at 8 for this core and not to be overridden.

Ports:
CLK  input  1  core clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
RDY  input  1  1 = advance; 0 = freeze every register (stall)
PCL_PCL  input  1  PCLS selects the PCL loop (hold/increment current low byte)
ADL_PCL  input  1  PCLS selects ADL_DATA
PCH_PCH  input  1  PCHS selects the PCH loop
ADH_PCH  input  1  PCHS selects ADH_DATA
I_PC  input  1  increment request (+1 on the selected 16-bit value)
PCL_DB  input  1  drive PCL onto DB_OUT
PCL_ADL  input  1  drive PCL onto ADL_OUT
PCH_DB  input  1  drive PCH onto DB_OUT
PCH_ADH  input  1  drive PCH onto ADH_OUT
ADL_DATA  input  8  address-low bus value
ADH_DATA  input  8  address-high bus value
DB_OUT  output  8  data-bus drive value
DB_OE  output  1  DB_OUT valid
ADL_OUT  output  8  ADL drive value
ADL_OE  output  1  ADL_OUT valid
ADH_OUT  output  8  ADH drive value
ADH_OE  output  1  ADH_OUT valid
PC_OUT  output  16  {PCH,PCL}, for debug and trace
PCL_LOOP  output  8  registered PCL, fed back to the PCLS select stage

Behaviour:
- Reset: asynchronous and active-high. While RST=1, PCL=RESET_PC[7:0] and PCH=RESET_PC[15:8]. All *_OE=0 and all bus outputs=8'h00. A reset mid-increment discards the pending update.
- Select stage, low byte: ADL_PCL=1 -> ADL_DATA; else PCL_PCL=1 -> PCL; else the previously selected low value (the select latch holds).
- Select stage, high byte: same rule with ADH_PCH, PCH_PCH and ADH_DATA. ADL/ADH has priority over the loop when both selects are high.
- The select latches are registers updated on the same edge as PCL/PCH. With no select asserted, the held value is the last selected one, not the current PC.
- Increment: sel16={selH,selL}; next = I_PC ? sel16+1 : sel16, computed modulo 2^16.
  - Carry from the low byte into the high byte happens in the same cycle.
  - 16'hFFFF+1 wraps to 16'h0000; no flag is raised.
- Register update: on the CLK rising edge with RDY=1, {PCH,PCL}<=next and the select latches <=selH/selL. With RDY=0, nothing changes, including the select latches.
- Latency: a select/increment request issued in cycle n is visible on PC_OUT/PCL_LOOP in cycle n+1.
- Bus drive is combinational from the registered PCL/PCH:
  - DB_OUT = PCL if PCL_DB; else PCH if PCH_DB; else 8'h00.
  - DB_OE = PCL_DB | PCH_DB. When both are asserted, PCL wins and the condition is flagged by an assertion in simulation.
  - ADL_OUT=PCL and ADL_OE=1 iff PCL_ADL; otherwise ADL_OUT=8'h00.
  - ADH_OUT=PCH and ADH_OE=1 iff PCH_ADH; otherwise ADH_OUT=8'h00.
- Nothing on the bus side latches: bus outputs follow the enables in the same cycle.

Optional Feature:
- Macro: PC_BREAK_EN.
- When defined:
  - Adds input BRK_ADDR[15:0], input BRK_ARM and output BRK_HIT.
  - BRK_HIT is registered. It is set on the edge where next==BRK_ADDR with BRK_ARM=1 and RDY=1, and is sticky until BRK_ARM=0 or RST.
  - Reset value of BRK_HIT is 0.
- When undefined: those ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package cpu6502_pkg holds:
  - RESET_PC default, 16'hFFFC.
  - Bus idle value, 8'h00.
  - Typedef pc_t (16-bit) and typedef byte_t (8-bit).
- Sub-module pc_half is instantiated twice (low and high). It contains the select latch, the register, the carry-in/carry-out increment, and reset to its parameterised byte.
  - The low half takes carry-in = I_PC.
  - The high half takes carry-in = low carry-out.

Test Plan:
- Reset: assert RST mid-cycle -> PC_OUT=16'hFFFC immediately and all *_OE=0. Release RST, then PCL_PCL=PCH_PCH=I_PC=1 for 3 cycles -> PC_OUT steps 16'hFFFD, 16'hFFFE, 16'hFFFF.
- Wrap: PC=16'h12FF, loop select, I_PC=1 -> 16'h1300 next cycle. PC=16'hFFFF -> 16'h0000.
- Jump load: ADL_DATA=8'h34, ADH_DATA=8'h56, ADL_PCL=ADH_PCH=1, I_PC=0 -> PC_OUT=16'h5634. Same inputs with I_PC=1 -> 16'h5635. With PCL_PCL also high -> ADL still wins.
- Stall: RDY=0 for 4 cycles with I_PC=1 -> PC_OUT constant. RDY=1 -> resumes +1 per cycle.
- Bus drive: PC=16'hABCD, PCL_ADL=1 and PCH_ADH=1 -> ADL_OUT=8'hCD, ADH_OUT=8'hAB, both OE=1. PCH_DB=1 alone -> DB_OUT=8'hAB. All enables low -> all outputs 8'h00 and OE=0.
- PC_BREAK_EN: BRK_ADDR=16'h0203, BRK_ARM=1, increment from 16'h0200 -> BRK_HIT rises on the edge where PC becomes 16'h0203 and stays high. BRK_ARM=0 -> BRK_HIT clears.
